// File: rtl/count_frame_packer.sv
// Snapshots the coincidence counter bank on each integration strobe and streams it as a framed, XOR-checked byte sequence.
// First byte valid one cycle after the strobe; each byte holds under tx_ready backpressure, and strobes arriving mid-frame are dropped and flagged.
module count_frame_packer #(
   parameter int NUM_INPUTS     = 12,
   parameter int NUM_WORDS      = NUM_INPUTS * (NUM_INPUTS - 1) / 2,
   parameter int RESOLUTION     = 16,
   parameter int BYTES_PER_WORD = (RESOLUTION + 7) / 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              integration_clk_pulse,
   input  logic [NUM_WORDS*RESOLUTION-1:0]   counts_in,
   output logic [7:0]                        tx_data,
   output logic                              tx_valid,
   input  logic                              tx_ready,
   output logic                              busy,
   output logic                              overrun
);

   localparam int WW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int BW   = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
   localparam int PADW = BYTES_PER_WORD * 8;
   localparam logic [WW-1:0] LAST_W = WW'(NUM_WORDS - 1);
   localparam logic [BW-1:0] LAST_B = BW'(BYTES_PER_WORD - 1);

   typedef enum logic [2:0] {IDLE, HDR0, HDR1, SEQ, STAT, DATA, CSUM} state_t;

   state_t                          state;
   logic [NUM_WORDS*RESOLUTION-1:0] snapshot;
   logic [WW-1:0]                   w_idx;
   logic [BW-1:0]                   b_idx;
   logic [7:0]                      seq;
   logic [7:0]                      csum;
   logic                            ovr_flag;

   logic                  xfer;
   logic                  drop;
   logic                  last_b;
   logic                  last_w;
   logic [WW-1:0]         sel_w;
   logic [BW-1:0]         sel_b;
   logic [RESOLUTION-1:0] sel_word;
   logic [PADW-1:0]       padded;
   int                    sel_pos;
   logic [7:0]            sel_byte;

   assign xfer   = tx_valid && tx_ready;
   assign drop   = integration_clk_pulse && (state != IDLE);
   assign last_b = (b_idx == LAST_B);
   assign last_w = (w_idx == LAST_W);

   // Position of the byte that goes on the bus after the current transfer; STAT always leads into word 0, byte 0.
   always_comb begin
      sel_w = w_idx;
      sel_b = b_idx;
      if (state != DATA) begin
         sel_w = '0;
         sel_b = '0;
      end else if (last_b) begin
         sel_w = last_w ? w_idx : w_idx + 1'b1;
         sel_b = '0;
      end else begin
         sel_b = b_idx + 1'b1;
      end
      sel_word = snapshot[32'(sel_w) * RESOLUTION +: RESOLUTION];
      padded   = '0;
      padded[RESOLUTION-1:0] = sel_word;
      sel_pos  = (BYTES_PER_WORD - 1 - int'(sel_b)) * 8;
      sel_byte = padded[sel_pos +: 8];
   end

   // Contents are irrelevant until a strobe is accepted, so no reset is needed here.
   always_ff @(posedge clk) begin
      if (state == IDLE && integration_clk_pulse) begin
         snapshot <= counts_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
         busy     <= 1'b0;
         overrun  <= 1'b0;
         seq      <= 8'h00;
         ovr_flag <= 1'b0;
         csum     <= 8'h00;
         w_idx    <= '0;
         b_idx    <= '0;
      end else begin
         overrun <= drop;
         case (state)
            IDLE: begin
               if (integration_clk_pulse) begin
                  state    <= HDR0;
                  tx_valid <= 1'b1;
                  tx_data  <= 8'hA5;
                  busy     <= 1'b1;
                  csum     <= 8'h00;
               end
            end
            HDR0: begin
               if (xfer) begin
                  state   <= HDR1;
                  tx_data <= 8'h5A;
               end
            end
            HDR1: begin
               if (xfer) begin
                  state   <= SEQ;
                  tx_data <= seq;
               end
            end
            SEQ: begin
               if (xfer) begin
                  state   <= STAT;
                  csum    <= csum ^ tx_data;
                  // A drop on this very edge is already reported in the status byte.
                  tx_data <= {7'b0, ovr_flag | drop};
               end
            end
            STAT: begin
               if (xfer) begin
                  state    <= DATA;
                  csum     <= csum ^ tx_data;
                  ovr_flag <= 1'b0;
                  w_idx    <= '0;
                  b_idx    <= '0;
                  tx_data  <= sel_byte;
               end
            end
            DATA: begin
               if (xfer) begin
                  csum <= csum ^ tx_data;
                  if (last_b && last_w) begin
                     state   <= CSUM;
                     tx_data <= csum ^ tx_data;
                  end else begin
                     w_idx   <= sel_w;
                     b_idx   <= sel_b;
                     tx_data <= sel_byte;
                  end
               end
            end
            CSUM: begin
               if (xfer) begin
                  state    <= IDLE;
                  tx_valid <= 1'b0;
                  busy     <= 1'b0;
                  seq      <= seq + 8'd1;
               end
            end
            default: begin
               state    <= IDLE;
               tx_valid <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
         // Setting outranks the clear on the STAT transfer.
         if (drop) begin
            ovr_flag <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_count_frame_packer.sv
// Directed bench for count_frame_packer: default 12-channel instance plus a 3-channel, 12-bit instance.
module tb_count_frame_packer;

   localparam int NW   = 66;
   localparam int RES  = 16;
   localparam int FLEN = 137;

   logic               clk = 1'b0;
   logic               reset;
   logic               pulse;
   logic [NW*RES-1:0]  counts;
   logic [7:0]         tx_data;
   logic               tx_valid;
   logic               tx_ready;
   logic               busy;
   logic               overrun;

   logic               pulse12;
   logic [3*12-1:0]    counts12;
   logic [7:0]         tx_data12;
   logic               tx_valid12;
   logic               tx_ready12;
   logic               busy12;
   logic               overrun12;

   count_frame_packer u_dut (
      .clk                   (clk),
      .reset                 (reset),
      .integration_clk_pulse (pulse),
      .counts_in             (counts),
      .tx_data               (tx_data),
      .tx_valid              (tx_valid),
      .tx_ready              (tx_ready),
      .busy                  (busy),
      .overrun               (overrun)
   );

   count_frame_packer #(.NUM_INPUTS(3), .RESOLUTION(12)) u_dut12 (
      .clk                   (clk),
      .reset                 (reset),
      .integration_clk_pulse (pulse12),
      .counts_in             (counts12),
      .tx_data               (tx_data12),
      .tx_valid              (tx_valid12),
      .tx_ready              (tx_ready12),
      .busy                  (busy12),
      .overrun               (overrun12)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int valid_cycles;
   int loop_cycles;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   logic [NW*RES-1:0] base_counts;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic build_exp(input logic [7:0] s, input logic [7:0] st, input logic [NW*RES-1:0] cnt);
      logic [7:0]  c;
      logic [15:0] wd;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      exp_q.push_back(s);
      exp_q.push_back(st);
      c = s ^ st;
      for (int i = 0; i < NW; i++) begin
         wd = cnt[i*RES +: RES];
         exp_q.push_back(wd[15:8]);
         exp_q.push_back(wd[7:0]);
         c = c ^ wd[15:8] ^ wd[7:0];
      end
      exp_q.push_back(c);
   endtask

   task automatic cmp_frame(input string tag);
      int bad;
      bad = 0;
      chk({tag, "_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         if (got_q[i] !== exp_q[i]) bad++;
      end
      chk({tag, "_bad_bytes"}, bad, 0);
   endtask

   // Strobe on one negedge, drop it on the next; optionally trash counts_in right after capture.
   task automatic strobe(input bit clobber);
      @(negedge clk);
      pulse = 1'b1;
      @(negedge clk);
      pulse = 1'b0;
      if (clobber) counts = '1;
   endtask

   // Starts on the negedge where the header is already on the bus; returns on the negedge of the last byte.
   task automatic collect(input int mode, input int inject_at, input int n_stop);
      logic       prev_stall;
      logic [7:0] prev_dat;
      int         cyc;
      prev_stall = 1'b0;
      prev_dat   = 8'h00;
      cyc        = 0;
      got_q.delete();
      valid_cycles = 0;
      while (got_q.size() < n_stop && cyc < 3000) begin
         tx_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (cyc == inject_at) pulse = 1'b1;
         if (inject_at >= 0 && cyc == inject_at + 1) begin
            pulse = 1'b0;
            chk("overrun_pulse", overrun, 1);
         end
         if (inject_at >= 0 && cyc == inject_at + 2) chk("overrun_one_cycle", overrun, 0);
         if (prev_stall) begin
            chk("stall_valid", tx_valid, 1);
            chk("stall_hold", tx_data, prev_dat);
         end
         if (tx_valid) valid_cycles++;
         if (tx_valid && tx_ready) got_q.push_back(tx_data);
         prev_stall = tx_valid && !tx_ready;
         prev_dat   = tx_data;
         cyc++;
         if (got_q.size() < n_stop) @(negedge clk);
      end
      loop_cycles = cyc;
      chk("byte_count", got_q.size(), n_stop);
   endtask

   task automatic after_frame();
      @(negedge clk);
      chk("busy_after", busy, 0);
      chk("valid_after", tx_valid, 0);
   endtask

   logic [7:0] exp12 [11];
   logic [7:0] got12 [$];

   initial begin
      reset    = 1'b1;
      pulse    = 1'b0;
      tx_ready = 1'b0;
      pulse12  = 1'b0;
      tx_ready12 = 1'b1;
      counts12 = {12'hFFF, 12'h123, 12'hABC};
      for (int i = 0; i < NW; i++) base_counts[i*RES +: RES] = 16'h0100 + 16'(i);
      counts = base_counts;
      exp12 = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h0F, 8'hFF, 8'h64};

      repeat (3) @(negedge clk);
      chk("rst_valid", tx_valid, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Single frame, no backpressure.
      strobe(0);
      chk("lat1_valid", tx_valid, 1);
      chk("lat1_hdr", tx_data, 8'hA5);
      chk("busy_on", busy, 1);
      collect(0, -1, FLEN);
      chk("f1_valid_cycles", valid_cycles, FLEN);
      chk("f1_loop_cycles", loop_cycles, FLEN);
      build_exp(8'd0, 8'd0, base_counts);
      cmp_frame("f1");
      after_frame();

      // Random backpressure.
      strobe(0);
      collect(1, -1, FLEN);
      build_exp(8'd1, 8'd0, base_counts);
      cmp_frame("bp");
      after_frame();

      // Overrun 10 cycles into a frame, then status reporting on the next two frames.
      strobe(0);
      collect(0, 10, FLEN);
      build_exp(8'd2, 8'd0, base_counts);
      cmp_frame("ovr_cur");
      after_frame();
      strobe(0);
      collect(0, -1, FLEN);
      build_exp(8'd3, 8'd1, base_counts);
      cmp_frame("ovr_next");
      chk("ovr_next_stat", got_q[3], 8'h01);
      after_frame();
      strobe(0);
      collect(0, -1, FLEN);
      build_exp(8'd4, 8'd0, base_counts);
      cmp_frame("ovr_after");
      after_frame();

      // Snapshot isolation.
      strobe(1);
      collect(0, -1, FLEN);
      build_exp(8'd5, 8'd0, base_counts);
      cmp_frame("iso");
      counts = base_counts;
      after_frame();

      // 256 back-to-back frames through the sequence wrap.
      for (int k = 0; k < 256; k++) begin
         strobe(0);
         collect(0, -1, FLEN);
         build_exp(8'((6 + k) % 256), 8'd0, base_counts);
         cmp_frame("wrap");
         if ((6 + k) % 256 == 255) chk("wrap_seq255", got_q[2], 8'hFF);
         if ((6 + k) % 256 == 0) chk("wrap_seq0", got_q[2], 8'h00);
      end
      after_frame();

      // Reset during DATA byte 40 with a pending overrun flag.
      strobe(0);
      collect(0, 10, 45);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_valid", tx_valid, 0);
      chk("midrst_busy", busy, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_idle", tx_valid, 0);
      strobe(0);
      collect(0, -1, FLEN);
      build_exp(8'd0, 8'd0, base_counts);
      cmp_frame("midrst_next");
      after_frame();

      // 12-bit resolution instance.
      @(negedge clk);
      pulse12 = 1'b1;
      @(negedge clk);
      pulse12 = 1'b0;
      for (int c = 0; c < 100 && got12.size() < 11; c++) begin
         if (tx_valid12 && tx_ready12) got12.push_back(tx_data12);
         if (got12.size() < 11) @(negedge clk);
      end
      chk("r12_len", got12.size(), 11);
      for (int i = 0; i < 11 && i < got12.size(); i++) chk("r12_byte", got12[i], exp12[i]);
      @(negedge clk);
      chk("r12_busy_after", busy12, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/count_frame_packer.md
Name: count_frame_packer

Overview:
- Downstream of the pulse conditioning and correlator stages.
- On each integration strobe, snapshots the bank of pairwise coincidence counters and serialises it as a framed byte stream for the UART transmitter.
- Byte-level valid/ready handshake toward the UART; adds header, sequence number, status and XOR checksum so the host can resynchronise and detect lost frames.

Parameters:
- NUM_INPUTS, 12, number of detector channels.
- NUM_WORDS, NUM_INPUTS*(NUM_INPUTS-1)/2 (66), counter words per frame.
- RESOLUTION, 16, bits per counter word (1..32).
- BYTES_PER_WORD, (RESOLUTION+7)/8 (2), bytes emitted per word.

Ports:
- clk  in  1  system clock (PLL output).
- reset  in  1  synchronous, active-high reset.
- integration_clk_pulse  in  1  one-cycle strobe marking the end of an integration period.
- counts_in  in  NUM_WORDS*RESOLUTION  flat counter bus; word i at bits [i*RESOLUTION +: RESOLUTION].
- tx_data  out  8  byte to UART transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART accepts the byte this cycle.
- busy  out  1  high whenever state != IDLE.
- overrun  out  1  one-cycle pulse when a strobe is dropped.

Behaviour:
- Reset values (all sync, active-high):
  - State, counters and flags: state=IDLE, tx_valid=0, tx_data=0x00, busy=0, overrun=0.
  - Sequence counter: seq=0.
  - Sticky status: ovr_flag=0.
  - Snapshot register contents: don't-care.
- Transfer occurs on a rising edge where tx_valid && tx_ready.
  - tx_data and tx_valid are held stable until that transfer.
  - tx_valid never drops without a transfer except on reset.
- Strobe acceptance:
  - A strobe is accepted only if state==IDLE at that edge.
  - On acceptance, counts_in is registered into the snapshot at the same edge, and state goes to HDR0.
  - tx_valid=1 and tx_data=0xA5 are asserted the next cycle (latency 1).
- Dropped strobes:
  - A strobe arriving while state!=IDLE is dropped, including during CSUM with a same-cycle transfer.
  - A drop pulses overrun for 1 cycle and sets ovr_flag.
- State machine (each transition occurs on a transfer):
  - HDR0 (0xA5) -> HDR1 (0x5A) -> SEQ (seq) -> STAT -> DATA -> CSUM -> IDLE.
- STAT byte:
  - Contents: {7'b0, ovr_flag}.
  - ovr_flag clears on the STAT transfer. A drop in that same cycle keeps it set, so set wins.
- DATA:
  - Word index w runs 0..NUM_WORDS-1; byte index b runs 0..BYTES_PER_WORD-1.
  - Each word is emitted MSB byte first, zero-padded on the top when RESOLUTION%8 != 0.
  - Leaves to CSUM after the final byte of word NUM_WORDS-1 transfers.
- Checksum:
  - XOR of the SEQ, STAT and all DATA bytes; headers are excluded.
  - Accumulated on each transfer; cleared on strobe acceptance.
- Sequence number: seq is 8-bit and increments on the CSUM transfer, wrapping 255->0.
- Frame length: 2+1+1+NUM_WORDS*BYTES_PER_WORD+1 bytes, which is 137 at defaults.
  - With tx_ready held high, a frame occupies exactly 137 consecutive cycles of tx_valid.
  - busy deasserts the cycle after the CSUM transfer.
- Snapshot isolation: counts_in changes after capture have no effect on the frame in flight.
- Reset mid-frame:
  - Frame is abandoned immediately: tx_valid=0 the next cycle, seq=0, ovr_flag=0.
  - Any partial frame is not resumed.
- tx_ready is ignored while tx_valid=0.

Test Plan:
- Reset, single frame: counts_in word i = 0x0100+i, tx_ready=1, one strobe -> bytes A5 5A 00 00 01 00 01 01 … 01 41, then checksum = XOR of bytes 3..136; 137 consecutive valid cycles; busy falls after; seq next frame = 01.
- Back-pressure: tx_ready toggled pseudo-randomly -> byte sequence identical to the first scenario; tx_data stable across every stalled cycle; no byte duplicated or lost.
- Overrun: second strobe 10 cycles into a frame -> overrun pulses 1 cycle; current frame unaffected; next frame STAT=0x01; the frame after that STAT=0x00.
- Snapshot isolation: counts_in changed to all-ones 1 cycle after the strobe -> the frame carries the original values.
- Wrap and width: 256 frames back-to-back -> seq 255 followed by 00. With RESOLUTION=12 and word=0xABC -> bytes 0A BC.
- Reset mid-frame: reset asserted during DATA byte 40 -> tx_valid=0 next cycle, busy=0. The following strobe produces a full frame with seq=00 and STAT=00.
